// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the decoder_scan_n block:
//   - state_t   : controller state encoding (ST_BLANK only when the
//                 DECODER_BLANKING_EN macro is defined)
//   - onehot()  : index -> one-hot vector (MAX_OUT wide, callers truncate)
//   - clog2()   : minimum counter width for a count range (at least 1 bit)
// ----------------------------------------------------------------------------
package decoder_pkg;

    // Widest address supported by onehot(); callers cast the result down.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT   = 2 ** MAX_SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
`ifdef DECODER_BLANKING_EN
        ,
        ST_BLANK  = 2'd3
`endif
    } state_t;

    function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] i_idx);
        return MAX_OUT'(1) << i_idx;
    endfunction

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= value) begin
                return w;
            end
        end
        return 32;
    endfunction

endpackage

// File: rtl/decoder_scan_n_scan_next_idx.sv
// ----------------------------------------------------------------------------
// scan_next_idx
// Combinational rotate-priority search for the next unmasked channel.
// Ports:
//   i_idx     : search origin
//   i_mask    : bit k = 1 -> channel k is not selectable
//   i_incl    : 1 = origin itself is a candidate, 0 = search strictly after it
//   o_idx     : first unmasked channel found (origin when none found)
//   o_found   : at least one candidate is unmasked
//   o_wrapped : the search passed the top index and rolled over to 0, i.e.
//               in exclusive mode the result is <= the origin
// ----------------------------------------------------------------------------
module scan_next_idx #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      i_idx,
    input  logic [2**SEL_W-1:0]   i_mask,
    input  logic                  i_incl,
    output logic [SEL_W-1:0]      o_idx,
    output logic                  o_found,
    output logic                  o_wrapped
);

    localparam int N_OUT = 2 ** SEL_W;

    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default before any branch, so no latch can be inferred.
    always_comb begin
        logic [SEL_W:0] v_sum;
        o_idx     = i_idx;
        o_found   = 1'b0;
        o_wrapped = 1'b0;
        v_sum     = '0;
        // Candidates are origin+0..N-1 (inclusive) or origin+1..N (exclusive);
        // the carry out of the SEL_W-bit sum marks a roll-over past the top.
        for (int k = 0; k < N_OUT; k++) begin
            v_sum = {1'b0, i_idx} + (SEL_W+1)'(k) + {{SEL_W{1'b0}}, ~i_incl};
            if (!o_found && !i_mask[v_sum[SEL_W-1:0]]) begin
                o_idx     = v_sum[SEL_W-1:0];
                o_found   = 1'b1;
                o_wrapped = v_sum[SEL_W];
            end
        end
    end

endmodule

// File: rtl/decoder_scan_n.sv
// ----------------------------------------------------------------------------
// decoder_scan_n
// Registered SEL_W -> 2**SEL_W one-hot decoder with a channel scanner.
//   scan = 0 : out <= 1 << sel every cycle (mask ignored)
//   scan = 1 : one-hot walks through unmasked channels, DWELL cycles each
// Optional macro DECODER_BLANKING_EN inserts BLANK all-zero cycles after each
// scan advance (idx already shows the new channel during the gap).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   en    : global enable (0 -> outputs cleared, idx held)
//   scan  : 0 = direct decode, 1 = scan
//   sel   : direct address / scan start point
//   mask  : bit k = 1 -> channel k skipped while scanning
//   out   : registered one-hot select, all-zero when inactive
//   idx   : index of current/next channel
//   wrap  : one-cycle pulse after an advance to a lower-or-equal index
// ----------------------------------------------------------------------------
module decoder_scan_n #(
    parameter int SEL_W = 3,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 scan,
    input  logic [SEL_W-1:0]     sel,
    input  logic [2**SEL_W-1:0]  mask,
    output logic [2**SEL_W-1:0]  out,
    output logic [SEL_W-1:0]     idx,
    output logic                 wrap
);

    import decoder_pkg::*;

    localparam int N_OUT = 2 ** SEL_W;
    // One width serves both the dwell and the blank phase counters.
    localparam int CNT_W = clog2((DWELL > BLANK) ? DWELL : BLANK);

    state_t             r_state, w_state_nxt;
    logic [N_OUT-1:0]   r_out,   w_out_nxt;
    logic [SEL_W-1:0]   r_idx,   w_idx_nxt;
    logic               r_wrap,  w_wrap_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
`ifdef DECODER_BLANKING_EN
    logic [CNT_W-1:0]   r_blank_cnt, w_blank_nxt;
`endif

    // One search engine: inclusive from sel when starting a scan,
    // exclusive from the current channel while scanning.
    logic [SEL_W-1:0]   w_srch_from;
    logic               w_srch_incl;
    logic [SEL_W-1:0]   w_srch_idx;
    logic               w_srch_found;
    logic               w_srch_wrapped;

    assign w_srch_from = (r_state == ST_SCAN) ? r_idx : sel;
    assign w_srch_incl = (r_state != ST_SCAN);

    scan_next_idx #(.SEL_W(SEL_W)) u_next (
        .i_idx     (w_srch_from),
        .i_mask    (mask),
        .i_incl    (w_srch_incl),
        .o_idx     (w_srch_idx),
        .o_found   (w_srch_found),
        .o_wrapped (w_srch_wrapped)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_idx_nxt   = r_idx;
        w_wrap_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
`ifdef DECODER_BLANKING_EN
        w_blank_nxt = r_blank_cnt;
`endif
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_out_nxt   = '0;
            w_cnt_nxt   = '0;
`ifdef DECODER_BLANKING_EN
            w_blank_nxt = '0;
`endif
        end else if (!scan) begin
            w_state_nxt = ST_DIRECT;
            w_out_nxt   = N_OUT'(onehot(MAX_SEL_W'(sel)));
            w_idx_nxt   = sel;
            w_cnt_nxt   = '0;
`ifdef DECODER_BLANKING_EN
            w_blank_nxt = '0;
`endif
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (!w_srch_found) begin
                        // Everything masked: park with out=0 and idx held.
                        w_out_nxt = '0;
                        w_cnt_nxt = '0;
                    end else if (r_out == '0 || mask[r_idx] ||
                                 r_cnt == CNT_W'(DWELL-1)) begin
                        // Advance on dwell expiry, on the current channel being
                        // masked, or when resuming from the parked (out=0) state.
                        w_idx_nxt  = w_srch_idx;
                        w_wrap_nxt = w_srch_wrapped;
                        w_cnt_nxt  = '0;
`ifdef DECODER_BLANKING_EN
                        w_state_nxt = ST_BLANK;
                        w_out_nxt   = '0;
                        w_blank_nxt = '0;
`else
                        w_out_nxt   = N_OUT'(onehot(MAX_SEL_W'(w_srch_idx)));
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
`ifdef DECODER_BLANKING_EN
                ST_BLANK: begin
                    if (r_blank_cnt == CNT_W'(BLANK-1)) begin
                        w_state_nxt = ST_SCAN;
                        w_blank_nxt = '0;
                        w_cnt_nxt   = '0;
                        // A channel masked during the gap is never driven; out=0
                        // in SCAN makes the next edge search onward from here.
                        w_out_nxt   = mask[r_idx] ? '0
                                                  : N_OUT'(onehot(MAX_SEL_W'(r_idx)));
                    end else begin
                        w_blank_nxt = r_blank_cnt + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    // Scan entry from IDLE or DIRECT.
                    w_state_nxt = ST_SCAN;
                    w_cnt_nxt   = '0;
                    if (w_srch_found) begin
                        w_idx_nxt = w_srch_idx;
                        w_out_nxt = N_OUT'(onehot(MAX_SEL_W'(w_srch_idx)));
                    end else begin
                        w_out_nxt = '0;
                    end
                end
            endcase
        end
    end

    // NOTE: registered state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_out       <= '0;
            r_idx       <= '0;
            r_wrap      <= 1'b0;
            r_cnt       <= '0;
`ifdef DECODER_BLANKING_EN
            r_blank_cnt <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_idx       <= w_idx_nxt;
            r_wrap      <= w_wrap_nxt;
            r_cnt       <= w_cnt_nxt;
`ifdef DECODER_BLANKING_EN
            r_blank_cnt <= w_blank_nxt;
`endif
        end
    end

    assign out  = r_out;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule

// File: doc/decoder_scan_n.md
# decoder_scan_n

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a built-in channel scanner. In direct mode it registers the decode of an address with enable. In scan mode it steps a one-hot output through all unmasked channels with a programmable dwell time. It drives multiplexed loads such as display digit anodes, LED banks and bus-slave selects, and replaces fixed combinational decoders wherever scanning or glitch-free registered selects are needed.

## Interface
- SEL_W, 3, address width; N_OUT = 2**SEL_W outputs (derived localparam)
- DWELL, 4, cycles each channel stays selected in scan mode, ≥1
- BLANK, 1, dead cycles between channels, ≥1 (used only with blanking macro)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  global enable
- scan  in  1  0 = direct decode, 1 = scan
- sel  in  SEL_W  direct address; scan start point
- mask  in  N_OUT  bit k = 1 → channel k skipped in scan mode (ignored in direct mode)
- out  out  N_OUT  registered one-hot select (all-zero when inactive)
- idx  out  SEL_W  index of current/next channel
- wrap  out  1  one-cycle pulse when scan wraps to a lower-or-equal index

## Operation
- States: IDLE, DIRECT, SCAN, BLANK (BLANK exists only with macro).
- Reset (async): state IDLE, out=0, idx=0, wrap=0, dwell counter=0, blank counter=0.
- en=0 (any state) → IDLE next edge: out=0, wrap=0, counters cleared, idx held.
- en=1, scan=0 → DIRECT: out <= 1<<sel, idx <= sel every cycle; mask ignored.
- en=1, scan=1 from IDLE/DIRECT → SCAN. Start index = sel if unmasked, else next unmasked above sel (wrapping). Dwell counter cleared.
- SCAN: out = 1<<idx. Counter counts 0..DWELL-1; at DWELL-1, idx <= next unmasked index strictly after idx (wrapping mod N_OUT), counter clears, out moves to the new channel on the same edge.
- wrap=1 for the cycle after any advance whose new idx ≤ old idx. With exactly one unmasked channel, wrap pulses every DWELL cycles and out stays constant.
- Current channel becomes masked mid-dwell → advance on the next edge regardless of counter.
- All channels masked → out=0, idx held, wrap=0, counter held at 0. Scan resumes from the next unmasked index after idx once any mask bit clears.
- scan drops to 0 mid-scan → DIRECT next edge (out = 1<<sel).
- sel changes during SCAN → ignored.

## Timing
- All outputs registered; nothing combinational from inputs to outputs.
- Direct mode latency: 1 cycle from sel/en to out.
- Scan: each unmasked channel is high for exactly DWELL consecutive cycles (no macro), with no overlap and no zero gap.
- Mask change takes effect at the next advance decision, worst case 1 cycle.
- DWELL=1: channel changes every cycle.

## Configuration
- DECODER_BLANKING_EN defined: each scan advance enters BLANK for BLANK cycles. During BLANK, out=0 and idx already shows the new channel. The channel then drives for DWELL cycles, so the period per channel is DWELL+BLANK. wrap is asserted on BLANK entry. en=0 or scan=0 during BLANK aborts to IDLE/DIRECT per normal rules.
- Undefined: no BLANK state, BLANK parameter ignored, outputs switch directly between channels.

## Structure
- Shared package decoder_pkg: state encoding constants, onehot(idx) function, clog2 helper for counter widths.
- One sub-module, scan_next_idx: combinational rotate-priority search. Inputs are current idx, mask and an inclusive/exclusive flag. Outputs are next unmasked index, a found flag and a wrapped flag. It is used for both the start-index and advance calculations.

## Test plan
- Direct: SEL_W=3, en=1, scan=0, sel=5 → out=8'b0010_0000, idx=5 one cycle later; en=0 → out=0 next cycle.
- Scan, DWELL=2, mask=0 → out walks 0x01,0x01,0x02,0x02,…,0x80,0x80,0x01; wrap high the cycle out returns to 0x01.
- Scan, mask=8'b1111_0101, sel=0 → start at idx 1, sequence 1,3,1,3…; wrap pulses on every 3→1 transition. Set mask=8'hFF → out=0, idx held.
- Mid-dwell mask of the current channel: DWELL=8, idx=2, set mask[2]=1 → next edge idx=3, out=0x08.
- Async reset asserted mid-scan between clock edges → out=0, idx=0, wrap=0 immediately. After release with en=1, scan=1, sel=0 → out=0x01 after one edge.
- With DECODER_BLANKING_EN, DWELL=2, BLANK=1 → pattern 0x01,0x01,0x00,0x02,0x02,0x00,…; no cycle has two bits set.
